// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer: assembles sync/opcode/A/B/checksum UART packets into a 66-bit command word
// and presents it to the task controller with a level-valid / ack handshake.
module uart_cmd_framer #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        cmd_ack,
  output logic [65:0] cmd_word,
  output logic        cmd_valid,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        overrun,
  output logic        busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {HUNT, OPC, A_BYTES, B_BYTES, CHK} state_t;
  state_t        r_state;
  logic [TW-1:0] r_tmo;
  logic [1:0]    r_cnt;
  logic [7:0]    r_chk;
  logic [1:0]    r_opc;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  assign busy = r_state != HUNT;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= HUNT;
      r_tmo     <= '0;
      r_cnt     <= '0;
      r_chk     <= '0;
      r_opc     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      cmd_word  <= '0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'b00;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (cmd_valid && cmd_ack) cmd_valid <= 1'b0;
      if (r_state == HUNT || rx_valid) r_tmo <= '0;
      else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
        frame_err <= 1'b1;
        err_code  <= 2'b10;
        r_state   <= HUNT;
        r_tmo     <= '0;
      end else r_tmo <= r_tmo + 1'b1;
      if (rx_valid) begin
        case (r_state)
          HUNT: if (rx_data == SYNC_BYTE) begin
            r_state <= OPC;
            r_chk   <= '0;
          end
          OPC: if (|rx_data[7:2]) begin
            frame_err <= 1'b1;
            err_code  <= 2'b11;
            r_state   <= HUNT;
          end else begin
            r_opc   <= rx_data[1:0];
            r_chk   <= r_chk ^ rx_data;
            r_cnt   <= '0;
            r_state <= A_BYTES;
          end
          A_BYTES: begin
            r_a   <= {r_a[23:0], rx_data};
            r_chk <= r_chk ^ rx_data;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == 2'd3) r_state <= B_BYTES;
          end
          B_BYTES: begin
            r_b   <= {r_b[23:0], rx_data};
            r_chk <= r_chk ^ rx_data;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == 2'd3) r_state <= CHK;
          end
          CHK: begin
            r_state <= HUNT;
            if (rx_data != r_chk) begin
              frame_err <= 1'b1;
              err_code  <= 2'b01;
            end else if (!cmd_valid || cmd_ack) begin
              // a same-cycle ack frees the slot, so the new word replaces the old one
              cmd_word  <= {r_b, r_a, r_opc};
              cmd_valid <= 1'b1;
            end else overrun <= 1'b1;
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end
endmodule

// File: doc/uart_cmd_framer.md
Name: uart_cmd_framer

Overview:
- Sits between the UART byte receiver and the FPGA-A task controller.
- Assembles an 11-byte serial command packet (sync, opcode, operand A, operand B, checksum) into the 66-bit command word the controller consumes.
- Validates the packet, then presents the word with a level-valid / ack handshake.
- Holds the word stable for the whole time the controller executes the task.

Parameters:
- SYNC_BYTE, 8'hA5: packet start marker.
- TIMEOUT_CYCLES, 100000: idle clocks allowed between bytes inside a packet (1 ms at 100 MHz); minimum 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  received UART byte.
- rx_valid  input  1  one-cycle strobe; rx_data is valid in the same cycle.
- cmd_ack  input  1  consumer finished with cmd_word (driven from controller done).
- cmd_word  output  66  [1:0] opcode, [33:2] A, [65:34] B; drives controller uart_in.
- cmd_valid  output  1  level; a new command is available; drives controller uart_ready.
- frame_err  output  1  one-cycle pulse on any packet error.
- err_code  output  2  01 checksum, 10 timeout, 11 bad opcode byte; holds last error.
- overrun  output  1  sticky; a good packet was dropped because cmd_valid was still high.
- busy  output  1  high whenever the state is not HUNT.

Behaviour:
- Reset, synchronous:
  - Outputs: cmd_word=0, cmd_valid=0, frame_err=0, err_code=00, overrun=0, busy=0.
  - state=HUNT; timeout counter, byte counter and checksum cleared.
  - A reset mid-packet discards the partial packet.
- Packet byte order:
  - SYNC_BYTE.
  - opcode byte: bits[7:2] must be 0.
  - A[31:24], A[23:16], A[15:8], A[7:0].
  - B[31:24] … B[7:0].
  - CHK = XOR of the 9 bytes from opcode through B[7:0].
- States:
  - HUNT: on rx_valid with rx_data==SYNC_BYTE go to OPC and clear the checksum; all other bytes are ignored silently.
  - OPC: on rx_valid, if rx_data[7:2]!=0 pulse frame_err, set err_code=11 and go to HUNT. Otherwise latch opcode, fold the byte into the checksum and go to A_BYTES.
  - A_BYTES / B_BYTES: a 2-bit counter shifts 4 bytes MSB-first into the A/B shadow registers, folding each into the checksum; go to B_BYTES / CHK after the 4th byte.
  - CHK: on rx_valid compare rx_data with the running XOR.
    - Mismatch: pulse frame_err, set err_code=01, go to HUNT.
    - Match: commit and go to HUNT.
- Commit timing:
  - cmd_word loads the shadow registers and cmd_valid=1 on the clock edge after the CHK-byte cycle.
  - Latency is 1 cycle from the CHK strobe to cmd_valid.
- Handshake:
  - cmd_valid stays high until sampled cmd_ack=1; it clears on the next edge.
  - cmd_word keeps its value after ack and is never modified while cmd_valid=1.
  - cmd_ack while cmd_valid=0 is ignored.
- Simultaneous events:
  - Commit in the same cycle as cmd_ack with cmd_valid=1: the new word loads and cmd_valid stays 1.
  - Commit with cmd_valid=1 and no ack: the packet is dropped, overrun=1 (sticky until reset), and cmd_word is unchanged.
- Timeout:
  - Outside HUNT, the counter increments each cycle without rx_valid and clears on rx_valid.
  - When the counter reaches TIMEOUT_CYCLES-1: pulse frame_err, set err_code=10, return to HUNT.
  - The counter is cleared on entry to HUNT.
- Opcode 2'b11 is legal at this layer; the consumer treats it as a no-op.
- Data bytes equal to SYNC_BYTE inside a packet are data, not resync.
- rx_valid strobes may arrive on consecutive cycles; the block accepts 1 byte per cycle with no drops.

Test Plan:
- ADD frame: A5 00 3F 80 00 00 40 00 00 00 FF → cmd_word opcode=00, A=3F800000, B=40000000; cmd_valid rises 1 cycle after the FF strobe and holds through 1000 idle cycles; cmd_ack pulse → cmd_valid=0 next edge, cmd_word unchanged.
- Same frame with last byte FE → frame_err pulse, err_code=01, cmd_valid stays 0.
- Then send A5 01 then stall TIMEOUT_CYCLES clocks → frame_err, err_code=10, busy=0.
- Back-to-back packets:
  - Second good packet (opcode 01) while the first is un-acked → overrun=1, cmd_word keeps the first packet.
  - Third packet whose CHK strobe coincides with cmd_ack → cmd_valid stays 1, cmd_word = third packet.
- Bytes 00 A5 04 → err_code=11 on the 04 byte; a following full valid frame is accepted normally.
- Assert reset after the 5th byte of a frame → all outputs zero next cycle; the remaining bytes of that frame produce no commit.
